// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle instruction control FSM; illegal-instruction trap enabled by CTRL_ILLEGAL_TRAP_EN
module ctrl_fsm #(
  parameter int OPW = 5,
  parameter int FW  = 4,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0] funct,
  input  logic          zero,
  input  logic          mem_ready,
  output logic [AW-1:0] ALUop,
  output logic          regWrite,
  output logic          memRead,
  output logic          memWrite,
  output logic          pcWrite,
  output logic          pcSel,
  output logic          busy,
  output logic          trap,
  input  logic          trap_ack
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  logic [2:0]     state, state_nxt;
  logic [OPW-1:0] op_q;
  logic [FW-1:0]  funct_q;
  logic [OPW-1:0] op_hi;
  logic [4:0]     op_lo;
  logic           is_r, is_ar, is_ld, is_st, is_brz, legal;
  logic [AW-1:0]  alu_code;

  // Only the low five opcode bits select the class; any set upper bit is illegal.
  assign op_hi  = op_q >> 5;
  assign op_lo  = op_q[4:0];
  assign is_r   = (op_hi == '0) && (op_lo == 5'b00000);
  assign is_ar  = (op_hi == '0) && (op_lo == 5'b00010);
  assign is_ld  = (op_hi == '0) && (op_lo == 5'b00100);
  assign is_st  = (op_hi == '0) && (op_lo == 5'b00101);
  assign is_brz = (op_hi == '0) && (op_lo == 5'b00110);
  assign legal  = (is_r && (funct_q <= FW'(8))) || is_ar || is_ld || is_st || is_brz;

  always_comb begin
    alu_code = '0;
    if (legal) begin
      if (is_r)        alu_code = AW'(funct_q[3:0]);
      else if (is_ar)  alu_code = AW'(4'b1111);
      else if (is_brz) alu_code = AW'(4'b0001);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && instr_valid) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    ALUop       = '0;
    regWrite    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    pcWrite     = 1'b0;
    pcSel       = 1'b0;
    trap        = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUop = alu_code;
        if (legal) begin
          state_nxt = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          pcWrite   = 1'b1;
          state_nxt = S_IDLE;
`endif
        end
      end
      S_EXEC: begin
        ALUop = alu_code;
        if (is_brz) begin
          pcWrite   = 1'b1;
          pcSel     = zero;
          state_nxt = S_IDLE;
        end else if (is_ld || is_st) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        ALUop    = alu_code;
        memRead  = is_ld;
        memWrite = is_st;
        if (mem_ready) begin
          if (is_ld) begin
            state_nxt = S_WB;
          end else begin
            pcWrite   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WB: begin
        ALUop     = alu_code;
        regWrite  = 1'b1;
        pcWrite   = 1'b1;
        state_nxt = S_IDLE;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        trap = 1'b1;
        if (trap_ack) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

`ifndef CTRL_ILLEGAL_TRAP_EN
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
`endif

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - table-driven and randomized checks of ctrl_fsm against an instruction-level model
module tb_ctrl_fsm;

  typedef struct packed {
    logic       rdy, bsy, rw, mrd, mwr, pcw, pcs, trp;
    logic [3:0] alu;
  } outs_t;

  typedef struct {
    logic       iv;
    logic [4:0] op;
    logic [3:0] fn;
    logic       z, mr, ta;
    outs_t      e;
  } vec_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [4:0] opcode = '0;
  logic [3:0] funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0, trap_ack = 1'b0;
  logic       instr_ready, regWrite, memRead, memWrite, pcWrite, pcSel, busy, trap;
  logic [3:0] ALUop;
  outs_t      got;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  vec_t tbl[$];
  vec_t rq[$];

  ctrl_fsm dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .ALUop(ALUop), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .pcWrite(pcWrite), .pcSel(pcSel), .busy(busy), .trap(trap), .trap_ack(trap_ack)
  );

  always #5 clk = ~clk;

  assign got = {instr_ready, busy, regWrite, memRead, memWrite, pcWrite, pcSel, trap, ALUop};

  function automatic outs_t o(bit rdy, bit bsy, bit rw, bit mrd, bit mwr, bit pcw, bit pcs, bit trp, logic [3:0] alu);
    return {rdy, bsy, rw, mrd, mwr, pcw, pcs, trp, alu};
  endfunction

  function automatic vec_t v(bit iv, logic [4:0] op, logic [3:0] fn, bit z, bit mr, bit ta, outs_t e);
    vec_t r;
    r.iv = iv; r.op = op; r.fn = fn; r.z = z; r.mr = mr; r.ta = ta; r.e = e;
    return r;
  endfunction

  function automatic outs_t idl();
    return o(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
  endfunction

  task automatic check(input string nm, input outs_t g, input outs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got={rdy,busy,rw,mrd,mwr,pcw,pcs,trap,alu}=%b_%h required=%b_%h",
               nm, cyc, g[11:4], g[3:0], e[11:4], e[3:0]);
    end
  endtask

  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    instr_valid = x.iv; opcode = x.op; funct = x.fn;
    zero = x.z; mem_ready = x.mr; trap_ack = x.ta;
    #1;
    check(nm, got, x.e);
    cyc++;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: expand one instruction into its expected per-cycle outputs from the ISA rules.
  task automatic gen_instr(input logic [4:0] op, input logic [3:0] fn, input bit z, input int waits, input int tw);
    bit         lgl, is_ld, is_st, is_brz, is_mem;
    logic [3:0] alu;
    lgl = 1; alu = 0;
    is_ld = (op == 5'd4); is_st = (op == 5'd5); is_brz = (op == 5'd6);
    is_mem = is_ld || is_st;
    case (op)
      5'd0: begin lgl = (fn <= 8); alu = lgl ? fn : 4'd0; end
      5'd2: alu = 4'hF;
      5'd4, 5'd5: alu = 4'h0;
      5'd6: alu = 4'h1;
      default: lgl = 0;
    endcase
    rq.push_back(v(1, op, fn, rb(), rb(), rb(), idl()));
    rq.push_back(v(rb(), 5'($urandom), 4'($urandom), rb(), rb(), rb(),
                   o(0, 1, 0, 0, 0, !lgl && !TRAP_EN, 0, 0, alu)));
    if (!lgl) begin
      if (TRAP_EN) begin
        for (int i = 0; i < tw; i++)
          rq.push_back(v(rb(), 5'($urandom), 4'($urandom), rb(), rb(), 0, o(0, 1, 0, 0, 0, 0, 0, 1, 0)));
        rq.push_back(v(rb(), 5'($urandom), 4'($urandom), rb(), rb(), 1, o(0, 1, 0, 0, 0, 0, 0, 1, 0)));
      end
      return;
    end
    if (is_brz) begin
      rq.push_back(v(rb(), 5'($urandom), 4'($urandom), z, rb(), rb(), o(0, 1, 0, 0, 0, 1, z, 0, alu)));
      return;
    end
    rq.push_back(v(rb(), 5'($urandom), 4'($urandom), rb(), rb(), rb(), o(0, 1, 0, 0, 0, 0, 0, 0, alu)));
    if (is_mem) begin
      for (int i = 0; i < waits; i++)
        rq.push_back(v(rb(), 5'($urandom), 4'($urandom), rb(), 0, rb(), o(0, 1, 0, is_ld, is_st, 0, 0, 0, alu)));
      rq.push_back(v(rb(), 5'($urandom), 4'($urandom), rb(), 1, rb(), o(0, 1, 0, is_ld, is_st, is_st, 0, 0, alu)));
      if (is_st) return;
    end
    rq.push_back(v(rb(), 5'($urandom), 4'($urandom), rb(), rb(), rb(), o(0, 1, 1, 0, 0, 1, 0, 0, alu)));
  endtask

  initial begin
    // R ADD: regWrite in the third cycle after accept
    tbl.push_back(v(1, 5'b00000, 4'd0, 0, 1, 1, idl()));
    tbl.push_back(v(0, 5'b11111, 4'd15, 1, 1, 1, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(1, 5'b00110, 4'd9, 1, 1, 1, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00100, 4'd3, 0, 1, 1, o(0, 1, 1, 0, 0, 1, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, idl()));
    // R SRL (funct 8, largest legal)
    tbl.push_back(v(1, 5'b00000, 4'd8, 0, 0, 0, idl()));
    tbl.push_back(v(0, 5'b00010, 4'd1, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd8)));
    tbl.push_back(v(0, 5'b00010, 4'd1, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd8)));
    tbl.push_back(v(0, 5'b00010, 4'd1, 0, 0, 0, o(0, 1, 1, 0, 0, 1, 0, 0, 4'd8)));
    // AR
    tbl.push_back(v(1, 5'b00010, 4'd5, 0, 0, 0, idl()));
    tbl.push_back(v(0, 5'b00000, 4'd2, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'hF)));
    tbl.push_back(v(0, 5'b00000, 4'd2, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'hF)));
    tbl.push_back(v(0, 5'b00000, 4'd2, 0, 0, 0, o(0, 1, 1, 0, 0, 1, 0, 0, 4'hF)));
    // LD with two stalled MEM cycles
    tbl.push_back(v(1, 5'b00100, 4'd7, 0, 1, 0, idl()));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 1, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 1, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 1, 0, o(0, 1, 0, 1, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 1, 0, 0, 1, 0, 0, 4'd0)));
    // ST with one stall
    tbl.push_back(v(1, 5'b00101, 4'd0, 0, 0, 0, idl()));
    tbl.push_back(v(0, 5'b00100, 4'd0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00100, 4'd0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00100, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 1, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00100, 4'd0, 0, 1, 0, o(0, 1, 0, 0, 1, 1, 0, 0, 4'd0)));
    // BRZ taken then not taken, instr_valid held high throughout
    tbl.push_back(v(1, 5'b00110, 4'd0, 0, 0, 0, idl()));
    tbl.push_back(v(1, 5'b00000, 4'd3, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd1)));
    tbl.push_back(v(1, 5'b00000, 4'd3, 1, 0, 0, o(0, 1, 0, 0, 0, 1, 1, 0, 4'd1)));
    tbl.push_back(v(1, 5'b00110, 4'd0, 1, 0, 0, idl()));
    tbl.push_back(v(1, 5'b00010, 4'd0, 1, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd1)));
    tbl.push_back(v(1, 5'b00010, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 0, 1, 0, 0, 4'd1)));
    tbl.push_back(v(0, 5'b00010, 4'd0, 0, 0, 0, idl()));
`ifdef CTRL_ILLEGAL_TRAP_EN
    // opcode 11111 and R funct 9 trap until acknowledged
    tbl.push_back(v(1, 5'b11111, 4'd0, 0, 0, 1, idl()));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 1, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 1, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 1, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 1, o(0, 1, 0, 0, 0, 0, 0, 1, 4'd0)));
    tbl.push_back(v(1, 5'b00000, 4'd9, 0, 0, 1, idl()));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 1, o(0, 1, 0, 0, 0, 0, 0, 1, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, idl()));
`else
    // opcode 11111 and R funct 9 retire as NOPs
    tbl.push_back(v(1, 5'b11111, 4'd0, 0, 0, 1, idl()));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 1, o(0, 1, 0, 0, 0, 1, 0, 0, 4'd0)));
    tbl.push_back(v(1, 5'b00000, 4'd9, 0, 0, 1, idl()));
    tbl.push_back(v(0, 5'b00000, 4'd0, 1, 1, 1, o(0, 1, 0, 0, 0, 1, 0, 0, 4'd0)));
    tbl.push_back(v(0, 5'b00000, 4'd0, 0, 0, 0, idl()));
`endif

    // reset state, asynchronously asserted
    #3;
    check("reset_state", got, idl());
    repeat (2) @(negedge clk);
    check("reset_held", got, idl());
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], "table");

    // reset mid-MEM of ST aborts the stalled write at once
    apply(v(1, 5'b00101, 4'd0, 0, 0, 0, idl()), "st_accept");
    apply(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)), "st_decode");
    apply(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 4'd0)), "st_exec");
    apply(v(0, 5'b00000, 4'd0, 0, 0, 0, o(0, 1, 0, 0, 1, 0, 0, 0, 4'd0)), "st_mem_stall");
    #1 reset = 1'b1;
    #1 check("rst_mid_mem", got, idl());
    @(negedge clk);
    check("rst_mid_mem_held", got, idl());
    reset = 1'b0;
    apply(v(0, 5'b00000, 4'd0, 0, 1, 0, idl()), "after_reset_idle");

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      int         k;
      logic [4:0] op;
      k = $urandom_range(0, 9);
      case (k)
        0, 1: op = 5'd0;
        2:    op = 5'd2;
        3, 4: op = 5'd4;
        5:    op = 5'd5;
        6, 7: op = 5'd6;
        default: op = 5'($urandom);
      endcase
      gen_instr(op, 4'($urandom), rb(), $urandom_range(0, 3), $urandom_range(0, 2));
      for (int g = $urandom_range(0, 2); g > 0; g--)
        rq.push_back(v(0, 5'($urandom), 4'($urandom), rb(), rb(), rb(), idl()));
    end
    foreach (rq[i]) apply(rq[i], "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
